line_steer_ctrl: RTL and testbench
==================================

Name: line_steer_ctrl

Overview:
- Steering controller that sequences the buffered sensor datapath into motor commands for the line follower.
- Consumes the synchronised sensor outputs (sensor_l/m/r; black = 0, white = 1).
- Samples them once per control period, decodes a steering command, tracks lost-line time and runs a search/halt recovery.
- Drives the two motor-PWM blocks, and their shared period counter via count_reset.

Parameters:
- PERIOD, 2000000: clock cycles per control period (20 ms at 100 MHz); minimum 2.
- LOST_PERIODS, 5: consecutive all-white periods before entering SEARCH; minimum 1.
- SEARCH_PERIODS, 50: SEARCH periods without finding the line before HALT; minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- enable  input  1  run request; 0 forces IDLE.
- sensor_l  input  1  left sensor, already synchronised, 0 = black.
- sensor_m  input  1  middle sensor, already synchronised, 0 = black.
- sensor_r  input  1  right sensor, already synchronised, 0 = black.
- motor_l_cmd  output  2  left motor command: 00 stop, 01 forward, 10 reverse; 11 never driven.
- motor_r_cmd  output  2  right motor command, same encoding.
- count_reset  output  1  one-cycle pulse marking a period boundary.
- state  output  3  current state: IDLE 0, TRACK 1, LOST 2, SEARCH 3, HALT 4.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
- Reset values: state IDLE, period counter cnt 0, lost_cnt 0, search_cnt 0, motors 00/00, count_reset 0, last_turn LEFT.
- Reset has priority over enable and all sensor inputs, including mid-period.
- Period counter cnt:
  - Counts 0..PERIOD-1 while enable=1, then wraps to 0.
  - Held at 0 while enable=0.
  - "Boundary" means cnt == PERIOD-1 with enable=1.
- count_reset is registered and is 1 in the cycle after each boundary, 0 otherwise.
- Sensor inputs are sampled only at a boundary; values between boundaries are ignored.
- Decode of {l,m,r} at a boundary, giving {motor_l_cmd, motor_r_cmd}:
  - 101 or 000 or 010 -> FORWARD 01/01.
  - 001 -> GENTLE_LEFT 00/01, last_turn := LEFT.
  - 011 -> SHARP_LEFT 10/01, last_turn := LEFT.
  - 100 -> GENTLE_RIGHT 01/00, last_turn := RIGHT.
  - 110 -> SHARP_RIGHT 01/10, last_turn := RIGHT.
  - 111 -> no line.
- All outputs are registered. A decision made at a boundary is visible the next cycle, i.e. the same cycle as count_reset=1 (latency 1 from the boundary).
- FSM, evaluated at boundaries unless stated:
  - IDLE:
    - Motors 00/00.
    - With enable=1, at the first boundary go to TRACK and apply the decode as in TRACK.
  - TRACK:
    - Non-111 -> apply decode, stay in TRACK.
    - 111 -> go to LOST with lost_cnt := 1 and motors unchanged.
    - If LOST_PERIODS == 1, 111 goes directly to SEARCH.
  - LOST:
    - Non-111 -> go to TRACK, apply decode, lost_cnt := 0.
    - 111 -> lost_cnt += 1. When the incremented value equals LOST_PERIODS, go to SEARCH with search_cnt := 0.
    - Motors are held throughout LOST.
  - SEARCH:
    - Motors rotate toward last_turn: LEFT gives 10/01, RIGHT gives 01/10. The rotation is applied at the entry boundary.
    - Non-111 -> go to TRACK and apply decode.
    - 111 -> search_cnt += 1. When it equals SEARCH_PERIODS, go to HALT with motors 00/00.
  - HALT:
    - Motors 00/00.
    - Ignores sensors; leaves only via enable=0 or reset.
- enable=0, in any state at any cycle:
  - Next cycle: state IDLE, motors 00/00, cnt 0, lost_cnt and search_cnt 0, count_reset 0.
  - last_turn is retained.
- enable re-asserted: the counter restarts from 0, so the first boundary comes PERIOD cycles later.
- Counter widths are derived from the parameters (clog2). Counters never wrap beyond their terminal values.

Test Plan:
All scenarios use PERIOD=4, LOST_PERIODS=2, SEARCH_PERIODS=3.
1. Reset then enable=1 with sensors 101 -> count_reset pulses every 4 cycles; first pulse coincides with state=1 and motors 01/01; all outputs 0 before the pulse.
2. In TRACK, apply 011 at a boundary then 100 at the next -> motors 10/01 then 01/00. Toggling sensors mid-period has no effect.
3. From TRACK with 001 (last_turn LEFT), hold 111 -> boundary 1: state 2, motors 00/01; boundary 2: state 3, motors 10/01; three more boundaries: state 4, motors 00/00; held in 4 while sensors return to 101.
4. In SEARCH with last_turn RIGHT (motors 01/10), apply 110 at a boundary -> state 1, motors 01/10, lost and search counters cleared; a later 111 needs 2 boundaries to reach SEARCH again.
5. Deassert enable mid-period in LOST -> next cycle state 0, motors 00/00, no count_reset. Re-enable -> first boundary exactly 4 cycles later.
6. Assert reset_n=0 for one cycle mid-SEARCH with enable=1 -> next cycle all reset values. Resumes to TRACK at the boundary 4 cycles after reset_n=1.

Source files
------------

// File: rtl/line_steer_ctrl.sv
// -----------------------------------------------------------------------------
// line_steer_ctrl
//
// Steering controller for the line follower. Once per control period it samples
// the synchronised sensor triple, decodes a steering command, tracks how long
// the line has been lost, and runs a search / halt recovery. It also owns the
// period counter shared with the two motor-PWM blocks and announces each period
// boundary with a one-cycle count_reset pulse.
//
// Handshake / timing contract: there is no valid/ready pair. Sensors are sampled
// only on the boundary cycle (cnt == PERIOD-1 with enable=1). Every output is
// registered, so the decision taken at a boundary appears on the following
// cycle, together with count_reset=1.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   enable       in   run request; 0 forces IDLE on the next cycle
//   sensor_l/m/r in   synchronised sensors, 0 = black (line), 1 = white
//   motor_l_cmd  out  2b left motor: 00 stop, 01 forward, 10 reverse
//   motor_r_cmd  out  2b right motor, same encoding
//   count_reset  out  one-cycle pulse after each period boundary
//   state        out  3b FSM state: IDLE 0, TRACK 1, LOST 2, SEARCH 3, HALT 4
// -----------------------------------------------------------------------------
module line_steer_ctrl #(
    parameter int PERIOD         = 2000000,
    parameter int LOST_PERIODS   = 5,
    parameter int SEARCH_PERIODS = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sensor_l,
    input  logic       sensor_m,
    input  logic       sensor_r,
    output logic [1:0] motor_l_cmd,
    output logic [1:0] motor_r_cmd,
    output logic       count_reset,
    output logic [2:0] state
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LW = $clog2(LOST_PERIODS + 1);
    localparam int SW = $clog2(SEARCH_PERIODS + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(PERIOD - 1);
    localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_PERIODS);
    localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_PERIODS);

    localparam logic [1:0] M_STOP = 2'b00;
    localparam logic [1:0] M_FWD  = 2'b01;
    localparam logic [1:0] M_REV  = 2'b10;

    // last_turn encoding
    localparam logic TURN_LEFT  = 1'b0;
    localparam logic TURN_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRACK  = 3'd1,
        S_LOST   = 3'd2,
        S_SEARCH = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t         cur;
    logic [CW-1:0]  cnt;
    logic [LW-1:0]  lost_cnt;
    logic [SW-1:0]  search_cnt;
    logic           last_turn;

    logic [2:0]     sensors;
    logic           boundary;
    logic           line_found;
    logic [1:0]     dec_l;
    logic [1:0]     dec_r;
    logic           dec_turns;
    logic           dec_turn;
    logic [LW-1:0]  lost_next;
    logic [SW-1:0]  search_next;

    assign state       = cur;
    assign sensors     = {sensor_l, sensor_m, sensor_r};
    assign boundary    = enable && (cnt == CNT_LAST);
    assign line_found  = (sensors != 3'b111);
    assign lost_next   = lost_cnt + LW'(1);
    assign search_next = search_cnt + SW'(1);

    // Steering decode. Patterns with the line centred or ambiguous (000, 010,
    // 101) drive straight; the one-sided patterns steer and remember direction.
    always_comb begin
        dec_l     = M_FWD;
        dec_r     = M_FWD;
        dec_turns = 1'b0;
        dec_turn  = TURN_LEFT;
        case (sensors)
            3'b001: begin dec_l = M_STOP; dec_r = M_FWD;  dec_turns = 1'b1; dec_turn = TURN_LEFT;  end
            3'b011: begin dec_l = M_REV;  dec_r = M_FWD;  dec_turns = 1'b1; dec_turn = TURN_LEFT;  end
            3'b100: begin dec_l = M_FWD;  dec_r = M_STOP; dec_turns = 1'b1; dec_turn = TURN_RIGHT; end
            3'b110: begin dec_l = M_FWD;  dec_r = M_REV;  dec_turns = 1'b1; dec_turn = TURN_RIGHT; end
            default: begin dec_l = M_FWD; dec_r = M_FWD;  dec_turns = 1'b0; dec_turn = TURN_LEFT;  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur         <= S_IDLE;
            cnt         <= '0;
            lost_cnt    <= '0;
            search_cnt  <= '0;
            motor_l_cmd <= M_STOP;
            motor_r_cmd <= M_STOP;
            count_reset <= 1'b0;
            last_turn   <= TURN_LEFT;
        end else if (!enable) begin
            // last_turn deliberately survives a disable.
            cur         <= S_IDLE;
            cnt         <= '0;
            lost_cnt    <= '0;
            search_cnt  <= '0;
            motor_l_cmd <= M_STOP;
            motor_r_cmd <= M_STOP;
            count_reset <= 1'b0;
        end else begin
            cnt         <= boundary ? '0 : cnt + CW'(1);
            count_reset <= boundary;

            if (boundary) begin
                if (cur == S_HALT) begin
                    // Only disable or reset leaves HALT.
                    motor_l_cmd <= M_STOP;
                    motor_r_cmd <= M_STOP;
                end else if (line_found) begin
                    // Any non-halted state that sees the line resumes tracking.
                    cur         <= S_TRACK;
                    motor_l_cmd <= dec_l;
                    motor_r_cmd <= dec_r;
                    lost_cnt    <= '0;
                    search_cnt  <= '0;
                    if (dec_turns) begin
                        last_turn <= dec_turn;
                    end
                end else begin
                    case (cur)
                        S_IDLE, S_TRACK: begin
                            if (LOST_PERIODS == 1) begin
                                cur         <= S_SEARCH;
                                search_cnt  <= '0;
                                lost_cnt    <= LW'(1);
                                motor_l_cmd <= (last_turn == TURN_RIGHT) ? M_FWD : M_REV;
                                motor_r_cmd <= (last_turn == TURN_RIGHT) ? M_REV : M_FWD;
                            end else begin
                                // Motors keep their last command while lost.
                                cur      <= S_LOST;
                                lost_cnt <= LW'(1);
                            end
                        end
                        S_LOST: begin
                            lost_cnt <= lost_next;
                            if (lost_next == LOST_LAST) begin
                                cur         <= S_SEARCH;
                                search_cnt  <= '0;
                                motor_l_cmd <= (last_turn == TURN_RIGHT) ? M_FWD : M_REV;
                                motor_r_cmd <= (last_turn == TURN_RIGHT) ? M_REV : M_FWD;
                            end
                        end
                        S_SEARCH: begin
                            search_cnt <= search_next;
                            if (search_next == SEARCH_LAST) begin
                                cur         <= S_HALT;
                                motor_l_cmd <= M_STOP;
                                motor_r_cmd <= M_STOP;
                            end else begin
                                motor_l_cmd <= (last_turn == TURN_RIGHT) ? M_FWD : M_REV;
                                motor_r_cmd <= (last_turn == TURN_RIGHT) ? M_REV : M_FWD;
                            end
                        end
                        default: begin
                            cur <= cur;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_line_steer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_steer_ctrl
//
// Directed bench for line_steer_ctrl with PERIOD=4, LOST_PERIODS=2,
// SEARCH_PERIODS=3. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so every step() covers exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_line_steer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       sensor_l;
    logic       sensor_m;
    logic       sensor_r;
    logic [1:0] motor_l_cmd;
    logic [1:0] motor_r_cmd;
    logic       count_reset;
    logic [2:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic pulse_ok;
    logic held;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    line_steer_ctrl #(
        .PERIOD        (4),
        .LOST_PERIODS  (2),
        .SEARCH_PERIODS(3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .sensor_l   (sensor_l),
        .sensor_m   (sensor_m),
        .sensor_r   (sensor_r),
        .motor_l_cmd(motor_l_cmd),
        .motor_r_cmd(motor_r_cmd),
        .count_reset(count_reset),
        .state      (state)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sensors(input logic [2:0] s);
        {sensor_l, sensor_m, sensor_r} = s;
    endtask

    // Drives one full period starting with cnt at 0. Sensors are optionally
    // scrambled for the first three cycles; the boundary cycle always sees s.
    // pulse_ok: count_reset low for 3 cycles then high on the 4th.
    // held: state and motors unchanged during the first 3 cycles.
    task automatic run_period(input logic [2:0] s, input bit toggle);
        logic [6:0] snap;
        snap     = {state, motor_l_cmd, motor_r_cmd};
        pulse_ok = 1'b1;
        held     = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (toggle && i < 4) set_sensors(3'($urandom_range(0, 7)));
            else                 set_sensors(s);
            step();
            if (i < 4) begin
                if (count_reset !== 1'b0) pulse_ok = 1'b0;
                if ({state, motor_l_cmd, motor_r_cmd} !== snap) held = 1'b0;
            end else if (count_reset !== 1'b1) begin
                pulse_ok = 1'b0;
            end
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        set_sensors(3'b011);
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if ({state, motor_l_cmd, motor_r_cmd, count_reset} !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got st=%0d m=%b/%b cr=%b want all 0",
                         i, state, motor_l_cmd, motor_r_cmd, count_reset);
            end
        end
    endtask

    task automatic test_track_start();
        set_sensors(3'b101);
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if ({state, motor_l_cmd, motor_r_cmd, count_reset} !== 8'd0) begin
                tests_failed++;
                $display("FAIL start_quiet[%0d]: got st=%0d m=%b/%b cr=%b want all 0",
                         i, state, motor_l_cmd, motor_r_cmd, count_reset);
            end
        end
        step();
        tests_run++;
        if ({state, motor_l_cmd, motor_r_cmd, count_reset} !== {3'd1, 4'b0101, 1'b1}) begin
            tests_failed++;
            $display("FAIL start_pulse: got st=%0d m=%b/%b cr=%b want st=1 m=01/01 cr=1",
                     state, motor_l_cmd, motor_r_cmd, count_reset);
        end
        for (int k = 0; k < 2; k++) begin
            run_period(3'b101, 1'b0);
            tests_run++;
            if (pulse_ok !== 1'b1 || {state, motor_l_cmd, motor_r_cmd} !== {3'd1, 4'b0101}) begin
                tests_failed++;
                $display("FAIL start_repeat[%0d]: got pulse_ok=%b st=%0d m=%b/%b want 1 st=1 m=01/01",
                         k, pulse_ok, state, motor_l_cmd, motor_r_cmd);
            end
        end
    endtask

    task automatic test_decode();
        logic [2:0] vec [6];
        logic [3:0] exp [6];
        vec = '{3'b011, 3'b100, 3'b110, 3'b000, 3'b010, 3'b001};
        exp = '{4'b1001, 4'b0100, 4'b0110, 4'b0101, 4'b0101, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            run_period(vec[i], 1'b1);
            tests_run++;
            if (pulse_ok !== 1'b1 || held !== 1'b1) begin
                tests_failed++;
                $display("FAIL decode_timing[%0d]: got pulse_ok=%b held=%b want 1 1", i, pulse_ok, held);
            end
            tests_run++;
            if ({state, motor_l_cmd, motor_r_cmd} !== {3'd1, exp[i]}) begin
                tests_failed++;
                $display("FAIL decode[%0d] in=%b: got st=%0d m=%b/%b want st=1 m=%b",
                         i, vec[i], state, motor_l_cmd, motor_r_cmd, exp[i]);
            end
        end
    endtask

    // Entered with last_turn LEFT and motors 00/01.
    task automatic test_lost_halt();
        logic [2:0] vec [7];
        logic [6:0] exp [7];
        vec = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
        exp = '{{3'd2, 4'b0001}, {3'd3, 4'b1001}, {3'd3, 4'b1001}, {3'd3, 4'b1001},
                {3'd4, 4'b0000}, {3'd4, 4'b0000}, {3'd4, 4'b0000}};
        for (int i = 0; i < 7; i++) begin
            run_period(vec[i], 1'b0);
            tests_run++;
            if (pulse_ok !== 1'b1 || {state, motor_l_cmd, motor_r_cmd} !== exp[i]) begin
                tests_failed++;
                $display("FAIL lost_halt[%0d] in=%b: got pulse_ok=%b st=%0d m=%b/%b want 1 st=%0d m=%b",
                         i, vec[i], pulse_ok, state, motor_l_cmd, motor_r_cmd, exp[i][6:4], exp[i][3:0]);
            end
        end
    endtask

    task automatic test_search_recover();
        logic [2:0] vec [6];
        logic [6:0] exp [6];
        // Leave HALT with a disable pulse.
        enable = 1'b0;
        step();
        tests_run++;
        if ({state, motor_l_cmd, motor_r_cmd, count_reset} !== 8'd0) begin
            tests_failed++;
            $display("FAIL halt_exit: got st=%0d m=%b/%b cr=%b want all 0",
                     state, motor_l_cmd, motor_r_cmd, count_reset);
        end
        enable = 1'b1;
        vec = '{3'b100, 3'b111, 3'b111, 3'b110, 3'b111, 3'b111};
        exp = '{{3'd1, 4'b0100}, {3'd2, 4'b0100}, {3'd3, 4'b0110},
                {3'd1, 4'b0110}, {3'd2, 4'b0110}, {3'd3, 4'b0110}};
        for (int i = 0; i < 6; i++) begin
            run_period(vec[i], 1'b0);
            tests_run++;
            if (pulse_ok !== 1'b1 || {state, motor_l_cmd, motor_r_cmd} !== exp[i]) begin
                tests_failed++;
                $display("FAIL search_recover[%0d] in=%b: got pulse_ok=%b st=%0d m=%b/%b want 1 st=%0d m=%b",
                         i, vec[i], pulse_ok, state, motor_l_cmd, motor_r_cmd, exp[i][6:4], exp[i][3:0]);
            end
        end
    endtask

    task automatic test_disable_lost();
        run_period(3'b101, 1'b0);
        run_period(3'b111, 1'b0);
        tests_run++;
        if ({state, motor_l_cmd, motor_r_cmd} !== {3'd2, 4'b0101}) begin
            tests_failed++;
            $display("FAIL disable_setup: got st=%0d m=%b/%b want st=2 m=01/01",
                     state, motor_l_cmd, motor_r_cmd);
        end
        // Move to cnt=3 so the next edge would otherwise be a boundary.
        for (int i = 0; i < 3; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({state, motor_l_cmd, motor_r_cmd, count_reset} !== 8'd0) begin
                tests_failed++;
                $display("FAIL disable_idle[%0d]: got st=%0d m=%b/%b cr=%b want all 0",
                         i, state, motor_l_cmd, motor_r_cmd, count_reset);
            end
        end
        enable = 1'b1;
        run_period(3'b101, 1'b0);
        tests_run++;
        if (pulse_ok !== 1'b1 || held !== 1'b1 || {state, motor_l_cmd, motor_r_cmd} !== {3'd1, 4'b0101}) begin
            tests_failed++;
            $display("FAIL reenable: got pulse_ok=%b held=%b st=%0d m=%b/%b want 1 1 st=1 m=01/01",
                     pulse_ok, held, state, motor_l_cmd, motor_r_cmd);
        end
    endtask

    // Entered in TRACK with last_turn RIGHT; reset must bring it back to LEFT.
    task automatic test_reset_mid_search();
        logic [2:0] vec [2];
        logic [6:0] exp [2];
        run_period(3'b111, 1'b0);
        run_period(3'b111, 1'b0);
        tests_run++;
        if ({state, motor_l_cmd, motor_r_cmd} !== {3'd3, 4'b0110}) begin
            tests_failed++;
            $display("FAIL rst_setup: got st=%0d m=%b/%b want st=3 m=01/10",
                     state, motor_l_cmd, motor_r_cmd);
        end
        step();
        reset_n = 1'b0;
        step();
        tests_run++;
        if ({state, motor_l_cmd, motor_r_cmd, count_reset} !== 8'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: got st=%0d m=%b/%b cr=%b want all 0",
                     state, motor_l_cmd, motor_r_cmd, count_reset);
        end
        reset_n = 1'b1;
        run_period(3'b101, 1'b0);
        tests_run++;
        if (pulse_ok !== 1'b1 || held !== 1'b1 || {state, motor_l_cmd, motor_r_cmd} !== {3'd1, 4'b0101}) begin
            tests_failed++;
            $display("FAIL rst_resume: got pulse_ok=%b held=%b st=%0d m=%b/%b want 1 1 st=1 m=01/01",
                     pulse_ok, held, state, motor_l_cmd, motor_r_cmd);
        end
        vec = '{3'b111, 3'b111};
        exp = '{{3'd2, 4'b0101}, {3'd3, 4'b1001}};
        for (int i = 0; i < 2; i++) begin
            run_period(vec[i], 1'b0);
            tests_run++;
            if (pulse_ok !== 1'b1 || {state, motor_l_cmd, motor_r_cmd} !== exp[i]) begin
                tests_failed++;
                $display("FAIL rst_last_turn[%0d]: got pulse_ok=%b st=%0d m=%b/%b want 1 st=%0d m=%b",
                         i, pulse_ok, state, motor_l_cmd, motor_r_cmd, exp[i][6:4], exp[i][3:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        set_sensors(3'b000);
        test_reset();
        test_track_start();
        test_decode();
        test_lost_halt();
        test_search_recover();
        test_disable_lost();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
